if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It is the initiator side of the 2K instruction memory's read interface. It holds the PC and drives the 9-bit word address to the memory's asynchronous read port. It latches the returned word into the IF/ID pipeline register and applies stall, flush and branch/jump redirects from the hazard unit and ID stage. Out-of-range and misaligned fetches are detected and reported.

---
 rtl/if_fetch_unit_pkg.sv | 32 +++
 rtl/if_fetch_unit_if.sv | 33 +++
 rtl/if_fetch_unit_next_pc_mux.sv | 28 ++
 rtl/if_fetch_unit.sv | 98 +++++++++
 tb/tb_if_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types, constants and helpers for the MIPS instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned IM_AW    = 9;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  // Number of populated instruction-memory words; higher word indices fault.
  localparam logic [31:0] IM_WORDS = 32'd502;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic               valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{instr: NOP, pc: 32'h0000_0000,
                                   pc4: 32'h0000_0000, valid: 1'b0};

  // A fetch faults when the PC is not word aligned or its word index lies
  // beyond the populated part of the instruction memory.
  function automatic logic fetch_fault(input logic [31:0] pc);
    logic misaligned;
    logic out_of_range;
    misaligned   = (pc[1:0] != 2'b00);
    out_of_range = ({2'b00, pc[31:2]} >= IM_WORDS);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of control, memory and IF/ID signals around the fetch stage.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic                stall_i;
  logic                flush_i;
  logic                redirect_i;
  logic [31:0]         redirect_pc_i;
  logic [IM_AW-1:0]    im_addr_o;
  logic [INSTR_W-1:0]  im_rd_i;
  logic [31:0]         pc_o;
  logic [INSTR_W-1:0]  id_instr_o;
  logic [31:0]         id_pc_o;
  logic [31:0]         id_pc4_o;
  logic                id_valid_o;
  logic                fault_o;
  logic [31:0]         fault_pc_o;

  // Fetch-unit side.
  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, im_rd_i,
    output im_addr_o, pc_o, id_instr_o, id_pc_o, id_pc4_o, id_valid_o,
    fault_o, fault_pc_o
  );

  // Pipeline / memory side.
  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, im_rd_i,
    input  im_addr_o, pc_o, id_instr_o, id_pc_o, id_pc4_o, id_valid_o,
    fault_o, fault_pc_o
  );

endinterface

// File: rtl/if_fetch_unit_next_pc_mux.sv
// Next-PC selection: redirect beats stall beats sequential PC+4.
module next_pc_mux
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_next_pc
);

  // Sequential successor; wraps naturally modulo 2^32.
  assign o_pc4 = i_pc + 32'd4;

  // Priority select of the PC to load on the next edge.
  always_comb begin
    o_next_pc = o_pc4;
    if (i_redirect) begin
      o_next_pc = i_redirect_pc;
    end else if (i_stall) begin
      o_next_pc = i_pc;
    end else begin
      o_next_pc = o_pc4;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID register and sticky fetch-fault
// capture. Memory read is asynchronous, so a fetch completes in one cycle.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);

  logic [31:0]        r_pc;
  ifid_t              r_ifid;
  logic               r_fault;
  logic [31:0]        r_fault_pc;

  logic [31:0]        w_pc4;
  logic [31:0]        w_next_pc;
  logic               w_fault;
  logic [INSTR_W-1:0] w_fetch_word;
  logic               w_fault_set;

  next_pc_mux u_next_pc_mux (
    .i_pc          (r_pc),
    .i_stall       (bus.stall_i),
    .i_redirect    (bus.redirect_i),
    .i_redirect_pc (bus.redirect_pc_i),
    .o_pc4         (w_pc4),
    .o_next_pc     (w_next_pc)
  );

  assign w_fault = fetch_fault(r_pc);

  // Faulting fetches deliver a nop instead of whatever memory returns.
  always_comb begin
    w_fetch_word = bus.im_rd_i;
    if (w_fault) begin
      w_fetch_word = NOP;
    end else begin
      w_fetch_word = bus.im_rd_i;
    end
  end

  // A fault is recorded only for the first fetch that actually enters IF/ID.
  always_comb begin
    w_fault_set = 1'b0;
    if (!r_fault && w_fault && !bus.flush_i && !bus.stall_i) begin
      w_fault_set = 1'b1;
    end else begin
      w_fault_set = 1'b0;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // IF/ID register: flush inserts a bubble (keeping pc for debug), stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid <= IFID_RESET;
    end else if (bus.flush_i) begin
      r_ifid <= '{instr: NOP, pc: r_pc, pc4: w_pc4, valid: 1'b0};
    end else if (bus.stall_i) begin
      r_ifid <= r_ifid;
    end else begin
      r_ifid <= '{instr: w_fetch_word, pc: r_pc, pc4: w_pc4, valid: 1'b1};
    end
  end

  // Sticky fault flag and address of the first faulting fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0000_0000;
    end else if (w_fault_set) begin
      r_fault    <= 1'b1;
      r_fault_pc <= r_pc;
    end else begin
      r_fault    <= r_fault;
      r_fault_pc <= r_fault_pc;
    end
  end

  assign bus.im_addr_o  = r_pc[10:2];
  assign bus.pc_o       = r_pc;
  assign bus.id_instr_o = r_ifid.instr;
  assign bus.id_pc_o    = r_ifid.pc;
  assign bus.id_pc4_o   = r_ifid.pc4;
  assign bus.id_valid_o = r_ifid.valid;
  assign bus.fault_o    = r_fault;
  assign bus.fault_pc_o = r_fault_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit against a behavioural model.
module tb_if_fetch_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_fault_pc;

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory image: word k holds 32'h1000_0000 + k.
  assign bus.im_rd_i = 32'h1000_0000 + {23'd0, bus.im_addr_o};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_faults(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'd502);
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_idpc = 32'd0; m_idpc4 = 32'd0;
    m_valid = 1'b0; m_fault = 1'b0; m_fault_pc = 32'd0;
  endtask

  task automatic model_edge(input logic s, input logic f, input logic r, input logic [31:0] t);
    logic        flt;
    logic [31:0] word;
    logic [31:0] seq;
    seq  = m_pc + 32'd4;
    flt  = model_faults(m_pc);
    word = flt ? 32'd0 : 32'h1000_0000 + ((m_pc / 32'd4) % 32'd512);
    if (!m_fault && flt && !f && !s) begin
      m_fault = 1'b1; m_fault_pc = m_pc;
    end
    if (f) begin
      m_instr = 32'd0; m_valid = 1'b0; m_idpc = m_pc; m_idpc4 = seq;
    end else if (!s) begin
      m_instr = word; m_valid = 1'b1; m_idpc = m_pc; m_idpc4 = seq;
    end
    if (r) m_pc = t;
    else if (!s) m_pc = seq;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":pc"},       bus.pc_o, m_pc);
    chk({ctx, ":im_addr"},  {23'd0, bus.im_addr_o}, (m_pc / 32'd4) % 32'd512);
    chk({ctx, ":id_instr"}, bus.id_instr_o, m_instr);
    chk({ctx, ":id_pc"},    bus.id_pc_o, m_idpc);
    chk({ctx, ":id_pc4"},   bus.id_pc4_o, m_idpc4);
    chk({ctx, ":id_valid"}, {31'd0, bus.id_valid_o}, {31'd0, m_valid});
    chk({ctx, ":fault"},    {31'd0, bus.fault_o}, {31'd0, m_fault});
    chk({ctx, ":fault_pc"}, bus.fault_pc_o, m_fault_pc);
  endtask

  // Drive inputs just after an edge, take the next edge, check #1 later.
  task automatic step(input string ctx, input logic s, input logic f, input logic r,
                      input logic [31:0] t);
    bus.stall_i = s; bus.flush_i = f; bus.redirect_i = r; bus.redirect_pc_i = t;
    @(posedge clk);
    model_edge(s, f, r, t);
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse between clock edges; checked before the next edge.
  task automatic mid_reset(input string ctx);
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'd0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    chk({ctx, ":rst_pc"}, bus.pc_o, 32'h0000_0000);
    chk({ctx, ":rst_fault"}, {31'd0, bus.fault_o}, 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic        s, f, r;
    logic [31:0] t;
    n_cmp = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'd0;
    model_reset();
    #2;
    check_all("reset");
    #5;
    rst = 1'b0;

    // Free run: im_addr 1,2 and instructions 0,1 with valid from first edge.
    for (int k = 1; k <= 2; k++) begin
      step("run", 1'b0, 1'b0, 1'b0, 32'd0);
      chk("run_im_addr", {23'd0, bus.im_addr_o}, k);
      chk("run_instr", bus.id_instr_o, 32'h1000_0000 + k - 1);
      chk("run_valid", {31'd0, bus.id_valid_o}, 32'd1);
    end

    // Stall three edges at pc=8, then resume with no duplicate.
    for (int k = 0; k < 3; k++) begin
      step("stall", 1'b1, 1'b0, 1'b0, 32'd0);
      chk("stall_pc", bus.pc_o, 32'h8);
      chk("stall_instr", bus.id_instr_o, 32'h1000_0001);
    end
    step("resume", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("resume_instr", bus.id_instr_o, 32'h1000_0002);
    step("run", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("pre_branch_pc", bus.pc_o, 32'h10);

    // Taken branch: redirect plus flush.
    step("br", 1'b0, 1'b1, 1'b1, 32'h40);
    chk("br_pc", bus.pc_o, 32'h40);
    chk("br_bubble", {31'd0, bus.id_valid_o}, 32'd0);
    step("br_tgt", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("br_tgt_instr", bus.id_instr_o, 32'h1000_0010);
    chk("br_tgt_pc", bus.id_pc_o, 32'h40);
    chk("br_tgt_pc4", bus.id_pc4_o, 32'h44);

    // Redirect during stall: PC moves, IF/ID holds.
    step("rs", 1'b1, 1'b0, 1'b1, 32'h80);
    chk("rs_pc", bus.pc_o, 32'h80);
    chk("rs_hold_pc", bus.id_pc_o, 32'h40);
    chk("rs_hold_instr", bus.id_instr_o, 32'h1000_0010);
    step("rs_next", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rs_next_instr", bus.id_instr_o, 32'h1000_0020);

    // Delay slot: redirect without flush keeps the sequential instruction.
    step("ds", 1'b0, 1'b0, 1'b1, 32'h100);
    chk("ds_slot_instr", bus.id_instr_o, 32'h1000_0021);
    chk("ds_slot_valid", {31'd0, bus.id_valid_o}, 32'd1);

    // Randomized traffic, mostly in range.
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 6) == 0);
      r = ($urandom_range(0, 6) == 0);
      t = {22'd0, 8'($urandom_range(0, 255)), 2'b00} + ($urandom_range(0, 1) == 1 ? 32'h300 : 32'h0);
      if ($urandom_range(0, 15) == 0) t = t + 32'($urandom_range(1, 3));
      step("rand", s, f, r, t);
    end

    // Out-of-range fetch at word 502.
    mid_reset("rst1");
    step("oor_redir", 1'b0, 1'b0, 1'b1, 32'h7D8);
    step("oor", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("oor_instr", bus.id_instr_o, 32'h0);
    chk("oor_fault", {31'd0, bus.fault_o}, 32'd1);
    chk("oor_fault_pc", bus.fault_pc_o, 32'h7D8);
    step("oor2_redir", 1'b0, 1'b0, 1'b1, 32'h7E0);
    step("oor2", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("oor2_fault_pc", bus.fault_pc_o, 32'h7D8);

    // Misaligned fetch: flushed and stalled copies must not latch the fault.
    mid_reset("rst2");
    step("mis_redir", 1'b0, 1'b0, 1'b1, 32'h6);
    step("mis_flush", 1'b0, 1'b1, 1'b1, 32'h6);
    chk("mis_flush_fault", {31'd0, bus.fault_o}, 32'd0);
    step("mis_stall", 1'b1, 1'b0, 1'b0, 32'd0);
    chk("mis_stall_fault", {31'd0, bus.fault_o}, 32'd0);
    step("mis_load", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mis_fault", {31'd0, bus.fault_o}, 32'd1);
    chk("mis_fault_pc", bus.fault_pc_o, 32'h6);
    chk("mis_instr", bus.id_instr_o, 32'h0);

    // PC+4 wraps modulo 2^32.
    mid_reset("rst3");
    step("wrap_redir", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc", bus.pc_o, 32'h0);
    chk("wrap_pc4", bus.id_pc4_o, 32'h0);

    // Restart after an asynchronous reset fetches from PC_RESET.
    step("pre_rst", 1'b0, 1'b0, 1'b0, 32'd0);
    mid_reset("rst4");
    step("restart", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("restart_id_pc", bus.id_pc_o, 32'h0);
    chk("restart_instr", bus.id_instr_o, 32'h1000_0000);
    chk("restart_pc", bus.pc_o, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
